// File: rtl/dff.sv
// Clock-enabled storage cell with asynchronous active-low reset.
// Leaf element of pipo: one instance per data bit, positional order (q, d, clk, rst, en).
module dff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    input  logic             en
);

    // Reset wins over any edge; without en the cell never captures, even after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= RESET_VALUE;
        else if (en)
            q <= d;
    end

endmodule

// File: tb/tb_dff.sv
// Self-checking bench for dff: directed timing scenarios plus randomized cycles
// against a behavioural model, on a 1-bit cell and a 4-bit cell with a non-zero reset value.
module tb_dff;

    localparam logic [3:0] RV_W = 4'hA;

    logic       clk;
    logic       rst;
    logic       en;
    logic       d;
    logic       q;
    logic [3:0] dw;
    logic [3:0] qw;

    int vectors;
    int miscompares;

    dff dut (
        .q   (q),
        .d   (d),
        .clk (clk),
        .rst (rst),
        .en  (en)
    );

    dff #(.WIDTH(4), .RESET_VALUE(RV_W)) dut_w (
        .q   (qw),
        .d   (dw),
        .clk (clk),
        .rst (rst),
        .en  (en)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk1(input string name, input logic exp);
        vectors++;
        if (q !== exp) begin
            miscompares++;
            $display("FAIL %s: q=%b expected %b at %0t", name, q, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [3:0] exp);
        vectors++;
        if (qw !== exp) begin
            miscompares++;
            $display("FAIL %s: qw=%h expected %h at %0t", name, qw, exp, $time);
        end
    endtask

    // Reset at 30 ns with en low, release at 60 ns, then 10 clocks with d toggling.
    task automatic test_reset();
        #30 rst = 1'b0;
        #1;
        chk1("reset_assert", 1'b0);
        chkw("reset_assert_w", RV_W);
        #29 rst = 1'b1;
        #1;
        chk1("reset_release", 1'b0);
        chkw("reset_release_w", RV_W);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d  = ~d;
            dw = ~dw;
            #15 d = ~d;
            #15 d = ~d;
            @(posedge clk);
            #1;
            chk1("en_low_after_reset", 1'b0);
            chkw("en_low_after_reset_w", RV_W);
        end
    endtask

    task automatic test_capture();
        @(negedge clk);
        en = 1'b1;
        d  = 1'b1;
        @(posedge clk);
        #1;
        chk1("capture_one", 1'b1);
        @(negedge clk);
        d = 1'b0;
        @(posedge clk);
        #1;
        chk1("capture_zero", 1'b0);
    endtask

    task automatic test_hold();
        @(negedge clk);
        en = 1'b1;
        d  = 1'b1;
        @(posedge clk);
        #1;
        chk1("hold_preload", 1'b1);
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = ~d;
            @(posedge clk);
            #1;
            chk1("hold", 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        en = 1'b1;
        d  = 1'b1;
        @(posedge clk);
        #1;
        chk1("mid_reset_preload", 1'b1);
        #19 rst = 1'b0;
        #1;
        chk1("mid_reset_immediate", 1'b0);
        #39 rst = 1'b1;
        #1;
        chk1("mid_reset_after_release", 1'b0);
        d = 1'b1;
        @(posedge clk);
        #1;
        chk1("mid_reset_first_capture", 1'b1);
    endtask

    task automatic test_reset_edge();
        @(negedge clk);
        en  = 1'b1;
        d   = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk1("reset_across_edge", 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("reset_edge_released", 1'b0);
        @(posedge clk);
        #1;
        chk1("reset_edge_next_load", 1'b1);
    endtask

    task automatic test_glitch();
        @(negedge clk);
        en = 1'b1;
        d  = 1'b0;
        @(posedge clk);
        #1;
        chk1("glitch_preload", 1'b0);
        #20 d = 1'b1;
        #10 d = 1'b0;
        #1;
        chk1("glitch_between_edges", 1'b0);
        @(posedge clk);
        #1;
        chk1("glitch_edge", 1'b0);
    endtask

    // Model: an enabled edge with reset released loads d; a reset pulse forces the reset value.
    task automatic test_random();
        logic       exp;
        logic [3:0] expw;
        int         r;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp  = 1'b0;
        expw = RV_W;
        rst  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rst = 1'b1;
            d   = 1'($urandom);
            dw  = 4'($urandom);
            en  = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            if (r == 0) begin
                #3 rst = 1'b0;
                #1;
                exp  = 1'b0;
                expw = RV_W;
                chk1("rand_pulse", exp);
                chkw("rand_pulse_w", expw);
                #4 rst = 1'b1;
            end else if (r == 1) begin
                rst  = 1'b0;
                exp  = 1'b0;
                expw = RV_W;
            end
            #10 d = ~d;
            #10 d = ~d;
            if (rst && en) begin
                exp  = d;
                expw = dw;
            end
            @(posedge clk);
            #1;
            chk1("rand_q", exp);
            chkw("rand_qw", expw);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        en  = 1'b0;
        d   = 1'b0;
        dw  = 4'h0;
        test_reset();
        test_capture();
        test_hold();
        test_mid_reset();
        test_reset_edge();
        test_glitch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
